// File: rtl/axis_traffic_shaper.sv
// AXI4-Stream register slice that injects LFSR-driven bubbles and stall bursts,
// frames the stream with TLAST and keeps saturating throughput statistics.
module axis_traffic_shaper #(
    parameter int          DATA_WIDTH      = 64,
    parameter int          FRAME_BEATS     = 1024,
    parameter int          BUBBLE_THRESH   = 0,
    parameter int          STALL_THRESH    = 6,
    parameter int          STALL_MIN       = 20,
    parameter int          STALL_RAND_BITS = 4,
    parameter logic [31:0] LFSR_SEED       = 32'hACE12468,
    parameter int          CNT_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic                  clear_stats,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  total_cycles
);

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [31:0] SEED      = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam int          BEAT_W    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int          STALL_W   = $clog2(STALL_MIN + (1 << STALL_RAND_BITS)) + 1;

    localparam logic [BEAT_W-1:0]    LAST_IDX   = BEAT_W'(FRAME_BEATS - 1);
    localparam logic [7:0]           BUBBLE_T   = 8'(BUBBLE_THRESH);
    localparam logic [7:0]           STALL_T    = 8'(STALL_THRESH);
    localparam logic [STALL_W-1:0]   STALL_BASE = STALL_W'(STALL_MIN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic [31:0]         lfsr;
    logic [STALL_W-1:0]  stall_cnt;
    logic [BEAT_W-1:0]   beat_idx;
    logic                bubble_now;
    logic                stall_active;
    logic                stall_start;
    logic                slot_free;
    logic                load;

    assign bubble_now    = lfsr[7:0] < BUBBLE_T;
    assign stall_active  = stall_cnt != '0;
    assign stall_start   = !stall_active && (lfsr[15:8] < STALL_T);
    assign slot_free     = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !areset && enable && slot_free && !bubble_now && !stall_active;
    assign load          = s_axis_tvalid && s_axis_tready;

    // Everything random is frozen while disabled, so a stall resumes where it left off.
    always_ff @(posedge clk) begin
        if (areset) begin
            lfsr      <= SEED;
            stall_cnt <= '0;
        end else if (enable) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
            if (stall_active) begin
                stall_cnt <= stall_cnt - STALL_W'(1);
            end else if (stall_start) begin
                stall_cnt <= STALL_BASE + STALL_W'(lfsr[16 +: STALL_RAND_BITS]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            beat_idx      <= '0;
        end else if (load) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (beat_idx == LAST_IDX);
            beat_idx      <= (beat_idx == LAST_IDX) ? '0 : beat_idx + BEAT_W'(1);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                frame_count <= frame_count + CNT_WIDTH'(1);
            end
        end
    end

    // Statistics stick at all-ones; a clear in the same cycle as an increment wins.
    always_ff @(posedge clk) begin
        if (areset || clear_stats) begin
            stall_cycles <= '0;
            total_cycles <= '0;
        end else if (enable) begin
            if (total_cycles != CNT_MAX) begin
                total_cycles <= total_cycles + CNT_WIDTH'(1);
            end
            if (s_axis_tvalid && !s_axis_tready && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

endmodule
